// File: rtl/turn_controller.sv
// Connect-4 turn sequencer: cursor, drop launch, board commit, win/draw check.
// Optional per-turn timeout is compiled in with `define TURN_TIMEOUT_EN.
module turn_controller #(
    parameter int          NUM_COLS   = 7,
    parameter int          NUM_ROWS   = 6,
    parameter int          START_COL  = 3,
    parameter logic [23:0] TURN_LIMIT = 24'd5_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_drop,
    input  logic             token_ready,
    input  logic [2:0]       final_row,
    input  logic [2:0]       final_column,
    input  logic             win_detected,
    output logic             player_move,
    output logic             valid_move,
    output logic             player_turn,
    output logic [2:0]       column_index,
    output logic [5:0][15:0] board_red,
    output logic [5:0][15:0] board_grn,
    output logic             state_busy,
    output logic             game_over,
    output logic             winner,
    output logic             draw
);
    typedef enum logic [2:0] {
        SELECT, LAUNCH, DROPPING, COMMIT, CHECK, OVER
    } state_t;

    localparam logic [2:0] START_C = 3'(START_COL);
    localparam logic [2:0] LAST_C  = 3'(NUM_COLS - 1);
    localparam logic [5:0] CELLS   = 6'(NUM_COLS * NUM_ROWS);

    state_t     state;
    logic [5:0] move_count;
    logic [2:0] row_q;
    logic [2:0] col_q;
    logic [3:0] cur_bit;
    logic [3:0] commit_bit;
    logic       col_open;
    logic       drop_ok;

    // A column is open while its top cell is empty in both colours.
    assign cur_bit    = 4'd15 - {1'b0, column_index};
    assign commit_bit = 4'd15 - {1'b0, col_q};
    assign col_open   = ~board_red[0][cur_bit] & ~board_grn[0][cur_bit];
    assign drop_ok    = (state == SELECT) & btn_drop & col_open;
    assign state_busy = (state != SELECT) && (state != OVER);

`ifdef TURN_TIMEOUT_EN
    logic [23:0] turn_timer;
    logic        expired;

    assign expired = (state == SELECT) &&
                     (turn_timer == TURN_LIMIT - 24'd1);

    always_ff @(posedge clk) begin
        if (reset)
            turn_timer <= '0;
        else if (state != SELECT || drop_ok || expired)
            turn_timer <= '0;
        else
            turn_timer <= turn_timer + 24'd1;
    end
`else
    logic unused_limit;
    assign unused_limit = ^TURN_LIMIT;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SELECT;
            move_count   <= '0;
            row_q        <= '0;
            col_q        <= '0;
            player_move  <= 1'b0;
            valid_move   <= 1'b0;
            player_turn  <= 1'b0;
            column_index <= START_C;
            board_red    <= '0;
            board_grn    <= '0;
            game_over    <= 1'b0;
            winner       <= 1'b0;
            draw         <= 1'b0;
        end else begin
            player_move <= 1'b0;
            valid_move  <= 1'b0;
            unique case (state)
                SELECT: begin
                    if (btn_drop) begin
                        if (col_open) begin
                            player_move <= 1'b1;
                            valid_move  <= 1'b1;
                            state       <= LAUNCH;
                        end
                    end else if (btn_left && !btn_right) begin
                        if (column_index != 3'd0)
                            column_index <= column_index - 3'd1;
                    end else if (btn_right && !btn_left) begin
                        if (column_index != LAST_C)
                            column_index <= column_index + 3'd1;
                    end
`ifdef TURN_TIMEOUT_EN
                    if (expired && !drop_ok)
                        player_turn <= ~player_turn;
`endif
                end
                LAUNCH: state <= DROPPING;
                DROPPING: begin
                    if (token_ready) begin
                        row_q <= final_row;
                        col_q <= final_column;
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (player_turn)
                        board_grn[row_q][commit_bit] <= 1'b1;
                    else
                        board_red[row_q][commit_bit] <= 1'b1;
                    move_count <= move_count + 6'd1;
                    state      <= CHECK;
                end
                CHECK: begin
                    if (win_detected) begin
                        winner    <= player_turn;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else if (move_count == CELLS) begin
                        draw      <= 1'b1;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        player_turn <= ~player_turn;
                        state       <= SELECT;
                    end
                end
                OVER: begin
                    if (btn_drop) begin
                        board_red    <= '0;
                        board_grn    <= '0;
                        move_count   <= '0;
                        player_turn  <= 1'b0;
                        column_index <= START_C;
                        winner       <= 1'b0;
                        draw         <= 1'b0;
                        game_over    <= 1'b0;
                        state        <= SELECT;
                    end
                end
                default: state <= SELECT;
            endcase
        end
    end
endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller; timeout scenario runs when
// TURN_TIMEOUT_EN is defined (TURN_LIMIT set to 16 here).
module tb_turn_controller;
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             btn_left = 1'b0;
    logic             btn_right = 1'b0;
    logic             btn_drop = 1'b0;
    logic             token_ready = 1'b0;
    logic [2:0]       final_row = '0;
    logic [2:0]       final_column = '0;
    logic             win_detected = 1'b0;
    logic             player_move;
    logic             valid_move;
    logic             player_turn;
    logic [2:0]       column_index;
    logic [5:0][15:0] board_red;
    logic [5:0][15:0] board_grn;
    logic             state_busy;
    logic             game_over;
    logic             winner;
    logic             draw;

    int checks = 0;
    int errors = 0;

    turn_controller #(
        .NUM_COLS(7), .NUM_ROWS(6), .START_COL(3), .TURN_LIMIT(24'd16)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_left(btn_left), .btn_right(btn_right), .btn_drop(btn_drop),
        .token_ready(token_ready), .final_row(final_row),
        .final_column(final_column), .win_detected(win_detected),
        .player_move(player_move), .valid_move(valid_move),
        .player_turn(player_turn), .column_index(column_index),
        .board_red(board_red), .board_grn(board_grn),
        .state_busy(state_busy), .game_over(game_over),
        .winner(winner), .draw(draw)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic pulse_left();
        btn_left = 1'b1; cyc(); btn_left = 1'b0;
    endtask

    task automatic pulse_right();
        btn_right = 1'b1; cyc(); btn_right = 1'b0;
    endtask

    // Full turn: drop, landing report, then wait until the CHECK result shows.
    task automatic do_move(input logic [2:0] row, input logic [2:0] col,
                           output logic launched);
        btn_drop = 1'b1; cyc(); btn_drop = 1'b0;
        launched = player_move;
        if (launched) begin
            cyc();
            token_ready = 1'b1; final_row = row; final_column = col;
            cyc();
            token_ready = 1'b0;
            cyc();
            cyc();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (column_index !== 3'd3) begin errors++; $display("FAIL rst_col: got %0d expected 3", column_index); end
        checks++; if (player_turn !== 1'b0) begin errors++; $display("FAIL rst_turn: got %0b expected 0", player_turn); end
        checks++; if (board_red !== '0 || board_grn !== '0) begin errors++; $display("FAIL rst_board: got %h/%h expected 0", board_red, board_grn); end
        checks++; if ({player_move, valid_move, state_busy, game_over, winner, draw} !== 6'b0) begin errors++; $display("FAIL rst_flags: got %b expected 000000", {player_move, valid_move, state_busy, game_over, winner, draw}); end
    endtask

    task automatic test_basic();
        logic [2:0] exp_col;
        do_reset();
        exp_col = 3'd3;
        for (int i = 0; i < 3; i++) begin
            pulse_right();
            exp_col = exp_col + 3'd1;
            checks++; if (column_index !== exp_col) begin errors++; $display("FAIL right_step: got %0d expected %0d", column_index, exp_col); end
        end
        pulse_right();
        checks++; if (column_index !== 3'd6) begin errors++; $display("FAIL right_sat: got %0d expected 6", column_index); end
        token_ready = 1'b1; final_row = 3'd5; final_column = 3'd0;
        cyc();
        token_ready = 1'b0;
        cyc(); cyc();
        checks++; if (board_red !== '0 || state_busy !== 1'b0) begin errors++; $display("FAIL stray_token: got busy %0b expected 0", state_busy); end
        btn_drop = 1'b1; cyc(); btn_drop = 1'b0;
        checks++; if ({player_move, valid_move} !== 2'b11) begin errors++; $display("FAIL launch: got %b expected 11", {player_move, valid_move}); end
        cyc();
        checks++; if ({player_move, state_busy} !== 2'b01) begin errors++; $display("FAIL one_pulse: got %b expected 01", {player_move, state_busy}); end
        token_ready = 1'b1; final_row = 3'd5; final_column = 3'd6;
        cyc();
        token_ready = 1'b0;
        checks++; if (board_red[5][9] !== 1'b0) begin errors++; $display("FAIL early_bit: got %0b expected 0", board_red[5][9]); end
        cyc();
        checks++; if (board_red[5][9] !== 1'b1 || player_turn !== 1'b0) begin errors++; $display("FAIL commit_bit: got %0b/%0b expected 1/0", board_red[5][9], player_turn); end
        cyc();
        checks++; if (player_turn !== 1'b1 || state_busy !== 1'b0) begin errors++; $display("FAIL toggle: got %0b/%0b expected 1/0", player_turn, state_busy); end
        checks++; if (board_grn !== '0 || column_index !== 3'd6) begin errors++; $display("FAIL keep_col: got %0d expected 6", column_index); end
    endtask

    task automatic test_cursor();
        logic [2:0] exp_col [4] = '{3'd2, 3'd1, 3'd0, 3'd0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pulse_left();
            checks++; if (column_index !== exp_col[i]) begin errors++; $display("FAIL left_%0d: got %0d expected %0d", i, column_index, exp_col[i]); end
        end
        btn_left = 1'b1; btn_right = 1'b1; cyc(); btn_left = 1'b0; btn_right = 1'b0;
        checks++; if (column_index !== 3'd0) begin errors++; $display("FAIL both_btn: got %0d expected 0", column_index); end
        pulse_right();
        checks++; if (column_index !== 3'd1) begin errors++; $display("FAIL right_after: got %0d expected 1", column_index); end
    endtask

    task automatic test_full_column();
        logic l;
        do_reset();
        for (int j = 0; j < 6; j++) begin
            do_move(3'(5 - j), 3'd3, l);
            checks++; if (l !== 1'b1 || player_turn !== 1'((j + 1) & 1)) begin errors++; $display("FAIL fill_%0d: got launch %0b turn %0b", j, l, player_turn); end
        end
        checks++; if (board_red[5][12] !== 1'b1 || board_grn[0][12] !== 1'b1 || board_red[0][12] !== 1'b0) begin errors++; $display("FAIL col_bits: got %h/%h", board_red, board_grn); end
        btn_drop = 1'b1; cyc(); btn_drop = 1'b0;
        checks++; if (player_move !== 1'b0 || state_busy !== 1'b0) begin errors++; $display("FAIL full_drop: got %0b/%0b expected 0/0", player_move, state_busy); end
        cyc(); cyc();
        checks++; if (player_turn !== 1'b0 || state_busy !== 1'b0) begin errors++; $display("FAIL full_turn: got %0b/%0b expected 0/0", player_turn, state_busy); end
    endtask

    task automatic test_win();
        logic l;
        do_reset();
        do_move(3'd5, 3'd3, l);
        pulse_right();
        win_detected = 1'b1;
        do_move(3'd5, 3'd4, l);
        win_detected = 1'b0;
        checks++; if ({game_over, winner, draw, state_busy} !== 4'b1100) begin errors++; $display("FAIL win_flags: got %b expected 1100", {game_over, winner, draw, state_busy}); end
        checks++; if (player_turn !== 1'b1 || board_grn[5][11] !== 1'b1) begin errors++; $display("FAIL win_turn: got %0b/%0b expected 1/1", player_turn, board_grn[5][11]); end
        pulse_left();
        checks++; if (column_index !== 3'd4) begin errors++; $display("FAIL over_left: got %0d expected 4", column_index); end
        btn_drop = 1'b1; cyc(); btn_drop = 1'b0;
        checks++; if (board_red !== '0 || board_grn !== '0) begin errors++; $display("FAIL restart_board: got %h/%h expected 0", board_red, board_grn); end
        checks++; if ({game_over, winner, draw, player_turn, player_move} !== 5'b0 || column_index !== 3'd3) begin errors++; $display("FAIL restart_state: got %b col %0d expected 00000 col 3", {game_over, winner, draw, player_turn, player_move}, column_index); end
    endtask

    task automatic test_draw();
        logic l;
        do_reset();
        for (int i = 0; i < 3; i++) pulse_left();
        for (int c = 0; c < 7; c++) begin
            for (int j = 0; j < 6; j++) begin
                do_move(3'(5 - j), 3'(c), l);
                if (c == 6 && j == 4) begin
                    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL draw_early: got %0b expected 0", game_over); end
                end
            end
            checks++; if (l !== 1'b1) begin errors++; $display("FAIL draw_launch_%0d: got %0b expected 1", c, l); end
            if (c < 6) pulse_right();
        end
        checks++; if ({game_over, draw, state_busy} !== 3'b110) begin errors++; $display("FAIL draw_flags: got %b expected 110", {game_over, draw, state_busy}); end
        checks++; if (player_turn !== 1'b1) begin errors++; $display("FAIL draw_turn: got %0b expected 1", player_turn); end
        checks++; if (board_red[5] !== 16'hFE00 || board_red[4] !== 16'h0 || board_grn[0] !== 16'hFE00) begin errors++; $display("FAIL draw_board: got %h/%h", board_red, board_grn); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        btn_drop = 1'b1; cyc(); btn_drop = 1'b0;
        cyc();
        reset = 1'b1; cyc(); reset = 1'b0;
        checks++; if ({state_busy, player_move} !== 2'b00) begin errors++; $display("FAIL mid_reset: got %b expected 00", {state_busy, player_move}); end
        token_ready = 1'b1; final_row = 3'd5; final_column = 3'd3;
        cyc();
        token_ready = 1'b0;
        cyc(); cyc();
        checks++; if (board_red !== '0 || state_busy !== 1'b0) begin errors++; $display("FAIL mid_token: got busy %0b expected 0", state_busy); end
    endtask

`ifdef TURN_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 15; i++) cyc();
        checks++; if (player_turn !== 1'b0) begin errors++; $display("FAIL to_early: got %0b expected 0", player_turn); end
        cyc();
        checks++; if (player_turn !== 1'b1) begin errors++; $display("FAIL to_toggle: got %0b expected 1", player_turn); end
        for (int i = 0; i < 15; i++) cyc();
        btn_drop = 1'b1; cyc(); btn_drop = 1'b0;
        checks++; if (player_move !== 1'b1 || player_turn !== 1'b1) begin errors++; $display("FAIL to_drop: got %0b/%0b expected 1/1", player_move, player_turn); end
        cyc();
        token_ready = 1'b1; final_row = 3'd5; final_column = 3'd3;
        cyc();
        token_ready = 1'b0;
        cyc(); cyc();
        checks++; if (player_turn !== 1'b0 || board_grn[5][12] !== 1'b1) begin errors++; $display("FAIL to_move: got %0b/%0b expected 0/1", player_turn, board_grn[5][12]); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_cursor();
        test_full_column();
        test_win();
        test_draw();
        test_reset_mid();
`ifdef TURN_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/turn_controller.md
# turn_controller

Game-turn sequencer for the Connect-4 datapath. Owns the authoritative red/green board, the selection cursor and the active player. It converts button pulses into a single drop request for the token animation block, then waits for that block's placement report. It commits the token into the board, consults the external win checker, and either passes the turn, declares a draw, or ends the game.

## Interface
Parameters:
- NUM_COLS, 7: playable columns 0..NUM_COLS-1. Board bit for column c is [15-c].
- NUM_ROWS, 6: rows 0 (top) .. 5 (bottom).
- START_COL, 3: cursor column after reset or restart.
- TURN_LIMIT, 24'd5_000_000: cycles allowed per turn. Used only with TURN_TIMEOUT_EN.

Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- btn_left, in, 1: single-cycle pulse, debounced upstream.
- btn_right, in, 1: single-cycle pulse.
- btn_drop, in, 1: single-cycle pulse.
- token_ready, in, 1: animation reports that the token has landed.
- final_row, in, 3: landing row, valid with token_ready.
- final_column, in, 3: landing column, valid with token_ready.
- win_detected, in, 1: combinational result of the win checker, computed from board_red/board_grn.
- player_move, out, 1: one-cycle drop request to the animation.
- valid_move, out, 1: qualifies player_move.
- player_turn, out, 1: 0 = red, 1 = green.
- column_index, out, 3: cursor column.
- board_red, out, [5:0][15:0]: committed red tokens.
- board_grn, out, [5:0][15:0]: committed green tokens.
- state_busy, out, 1: high in any state other than SELECT and OVER.
- game_over, out, 1: game has ended.
- winner, out, 1: winning player; meaningful only when game_over=1 and draw=0.
- draw, out, 1: board filled with no winner.

## Operation
- States: SELECT, LAUNCH, DROPPING, COMMIT, CHECK, OVER.
- SELECT:
  - Priority is btn_drop > btn_left > btn_right.
  - btn_left and btn_right asserted in the same cycle, with no drop: no action.
  - btn_left decrements column_index, saturating at 0. btn_right increments it, saturating at NUM_COLS-1.
  - btn_drop is accepted only if board_red[0][15-col] and board_grn[0][15-col] are both 0. It then moves to LAUNCH.
  - btn_drop on a full column is ignored and the state remains SELECT.
- LAUNCH: player_move=1 and valid_move=1 for exactly one cycle, then DROPPING.
- DROPPING:
  - All buttons are ignored.
  - On token_ready, latch final_row/final_column and move to COMMIT.
- COMMIT:
  - Set [final_row][15-final_column] in board_red if player_turn=0, else in board_grn.
  - move_count (6-bit) increments. Next state CHECK.
- CHECK: the board is already updated, so win_detected is sampled this cycle. Priority order:
  - win_detected=1: go to OVER with winner=player_turn.
  - Otherwise, move_count == NUM_COLS*NUM_ROWS: go to OVER with draw=1.
  - Otherwise toggle player_turn and return to SELECT. The cursor is kept.
- OVER:
  - game_over=1. btn_left and btn_right are ignored.
  - btn_drop restarts the game: clear both boards, move_count=0, player_turn=0, column_index=START_COL, winner=0, draw=0, game_over=0. Next state SELECT.
- The block never writes a cell that is already occupied, because the top-row check gates each launch.

## Timing
- Reset values:
  - Outputs: player_move=0, valid_move=0, player_turn=0, column_index=START_COL, boards all 0, state_busy=0, game_over=0, winner=0, draw=0.
  - Internal: state=SELECT, move_count=0.
- btn_drop sampled in cycle N produces player_move=1 in cycle N+1.
- token_ready in cycle M produces:
  - board bit visible in cycle M+2 (COMMIT registers it);
  - CHECK in cycle M+2;
  - turn toggle or game_over visible in cycle M+3.
- Cursor updates are visible in the cycle after the button pulse.
- token_ready outside DROPPING is ignored.
- Reset mid-drop returns to reset values at the next edge. The animation block shares the same reset.

## Configuration
- TURN_TIMEOUT_EN defined:
  - A 24-bit turn timer is cleared on every entry to SELECT and counts each cycle spent in SELECT.
  - When it reaches TURN_LIMIT-1 with no accepted drop, player_turn toggles, the timer clears and the state remains SELECT. move_count is unchanged.
  - An accepted btn_drop in the same cycle as expiry wins; no toggle occurs.
- TURN_TIMEOUT_EN undefined: no timer logic; a turn waits indefinitely.

## Test plan
- Reset; three btn_right pulses then btn_drop; token_ready with final_row=5, final_column=6 -> column_index 6, one player_move pulse, board_red[5][9]=1, player_turn=1 three cycles after token_ready.
- Four btn_left pulses from column 3 -> column_index saturates at 0. btn_left and btn_right in the same cycle -> no change.
- Fill column 3 with six alternating drops, then a seventh btn_drop -> no player_move, state remains SELECT, turn unchanged.
- Drop with win_detected=1 held during CHECK -> game_over=1, winner=player_turn; later btn_left ignored; btn_drop -> boards cleared, player_turn=0, column_index=3.
- 42 drops with win_detected=0 -> draw=1, game_over=1 after the 42nd CHECK.
- With TURN_TIMEOUT_EN and TURN_LIMIT=16: idle in SELECT -> player_turn toggles after 16 cycles. btn_drop on the expiry cycle -> launch, no toggle.
